// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter onto a single-cycle-latency memory port.
// Define MEM_ARB_RR_EN for round-robin contention; default is data-priority with a fetch starvation limit.
module mem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_rd_pending;
    logic       r_owner_is_data;
    logic       r_last_grant;   // 1 = data was granted last
    logic       w_data_wins;
    logic       w_if_gnt;
    logic       w_d_gnt;
    logic       w_any_gnt;

    always_comb begin
        w_data_wins = 1'b1;
`ifdef MEM_ARB_RR_EN
        w_data_wins = ~r_last_grant;
`else
        w_data_wins = (r_wait_cnt < LP_MAX_WAIT);
`endif
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        // Grants are forced low while reset is held, since they are combinational.
        if (!reset) begin
            if (if_req && d_req) begin
                w_d_gnt  = w_data_wins;
                w_if_gnt = ~w_data_wins;
            end else begin
                w_if_gnt = if_req;
                w_d_gnt  = d_req;
            end
        end
    end

    assign w_any_gnt = w_if_gnt | w_d_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt      <= 4'd0;
            r_rd_pending    <= 1'b0;
            r_owner_is_data <= 1'b0;
            r_last_grant    <= 1'b0;
        end else begin
            r_rd_pending    <= w_if_gnt | (w_d_gnt & ~d_we);
            r_owner_is_data <= w_any_gnt ? w_d_gnt : r_owner_is_data;
            r_last_grant    <= w_any_gnt ? w_d_gnt : r_last_grant;
`ifdef MEM_ARB_RR_EN
            r_wait_cnt      <= 4'd0;
`else
            if (if_req && !w_if_gnt)
                r_wait_cnt <= (r_wait_cnt >= LP_MAX_WAIT) ? LP_MAX_WAIT : r_wait_cnt + 4'd1;
            else
                r_wait_cnt <= 4'd0;
`endif
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign mem_req   = w_any_gnt;
    assign mem_we    = w_d_gnt & d_we;
    assign mem_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_d_gnt ? d_wdata : '0;

    assign if_rvalid = r_rd_pending & ~r_owner_is_data;
    assign d_rvalid  = r_rd_pending & r_owner_is_data;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; contention expectations follow MEM_ARB_RR_EN.
module tb_mem_port_arbiter;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_rvalid;
        logic        e_d_rvalid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    mem_port_arbiter #(.XLEN(32), .AW(32), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
                                input logic eig, input logic edg, input logic ewe,
                                input logic [31:0] ea, input logic [31:0] ed,
                                input logic eirv, input logic edrv);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
        v.d_addr = da;  v.d_wdata = dd;  v.mem_rdata = mr;
        v.e_if_gnt = eig;  v.e_d_gnt = edg;  v.e_mem_req = eig | edg;  v.e_mem_we = ewe;
        v.e_mem_addr = ea;  v.e_mem_wdata = ed;
        v.e_if_rvalid = eirv;  v.e_d_rvalid = edrv;
        return v;
    endfunction

    task automatic check_now(input vec_t v, input string nm);
        if_req = v.if_req;  if_addr = v.if_addr;  d_req = v.d_req;  d_we = v.d_we;
        d_addr = v.d_addr;  d_wdata = v.d_wdata;  mem_rdata = v.mem_rdata;
        #1;
        n_vec++;
        if (if_gnt !== v.e_if_gnt || d_gnt !== v.e_d_gnt || mem_req !== v.e_mem_req ||
            mem_we !== v.e_mem_we || mem_addr !== v.e_mem_addr || mem_wdata !== v.e_mem_wdata ||
            if_rvalid !== v.e_if_rvalid || d_rvalid !== v.e_d_rvalid ||
            if_rdata !== v.mem_rdata || d_rdata !== v.mem_rdata) begin
            n_bad++;
            $display("FAIL %s: got gnt(i,d)=%b%b req=%b we=%b addr=%h wdata=%h rv(i,d)=%b%b rdata=%h/%h; want gnt=%b%b req=%b we=%b addr=%h wdata=%h rv=%b%b rdata=%h",
                     nm, if_gnt, d_gnt, mem_req, mem_we, mem_addr, mem_wdata, if_rvalid, d_rvalid,
                     if_rdata, d_rdata, v.e_if_gnt, v.e_d_gnt, v.e_mem_req, v.e_mem_we,
                     v.e_mem_addr, v.e_mem_wdata, v.e_if_rvalid, v.e_d_rvalid, v.mem_rdata);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        check_now(v, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if_req = 1'b0;  d_req = 1'b0;  d_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reads from both masters per masks; expected data-grant pattern given as a bit mask.
    task automatic run_seq(input string nm, input int n, input logic [15:0] ireq,
                           input logic [15:0] dreq, input logic [15:0] expd);
        logic prev_if_rd = 1'b0;
        logic prev_d_rd  = 1'b0;
        logic eig, edg;
        logic [31:0] ea;
        vec_t v;
        for (int i = 0; i < n; i++) begin
            edg = expd[i];
            eig = ireq[i] & ~expd[i];
            ea  = edg ? 32'h50 : (eig ? 32'h40 : 32'h0);
            v = mk(ireq[i], 32'h40, dreq[i], 1'b0, 32'h50, 32'h0, 32'hC0DE0000 + 32'(i),
                   eig, edg, 1'b0, ea, 32'h0, prev_if_rd, prev_d_rd);
            apply(v, $sformatf("%s[%0d]", nm, i));
            prev_if_rd = eig;
            prev_d_rd  = edg;
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = mk(0, 32'h00, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 0);
        tbl[1] = mk(1, 32'h10, 0, 0, 32'h00, 32'h0,        32'h0,        1, 0, 0, 32'h10, 32'h0,        0, 0);
        tbl[2] = mk(0, 32'h00, 0, 0, 32'h00, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h00, 32'h0,        1, 0);
        tbl[3] = mk(0, 32'h00, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0, 0, 32'h00, 32'h0,        0, 0);
        tbl[4] = mk(0, 32'h00, 1, 1, 32'h20, 32'h12345678, 32'h0,        0, 1, 1, 32'h20, 32'h12345678, 0, 0);
        tbl[5] = mk(0, 32'h00, 1, 0, 32'h24, 32'hAAAA5555, 32'h0,        0, 1, 0, 32'h24, 32'hAAAA5555, 0, 0);
        tbl[6] = mk(1, 32'h14, 0, 1, 32'h00, 32'hFFFFFFFF, 32'h11111111, 1, 0, 0, 32'h14, 32'h0,        0, 1);
        tbl[7] = mk(0, 32'h00, 1, 0, 32'h30, 32'h0,        32'h22222222, 0, 1, 0, 32'h30, 32'h0,        1, 0);
        tbl[8] = mk(0, 32'h00, 0, 0, 32'h00, 32'h0,        32'h33333333, 0, 0, 0, 32'h00, 32'h0,        0, 1);

        // Reset held with both masters requesting: everything must stay quiet.
        apply(mk(1, 32'h10, 1, 1, 32'h20, 32'h55, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0), "in_reset_a");
        apply(mk(1, 32'h10, 1, 0, 32'h20, 32'h55, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0), "in_reset_b");
        do_reset();

        for (int i = 0; i < 9; i++)
            apply(tbl[i], $sformatf("tbl[%0d]", i));

`ifdef MEM_ARB_RR_EN
        do_reset();
        run_seq("contend", 10, 16'h3FF, 16'h3FF, 16'h155);
        do_reset();
        run_seq("if_gap", 9, 16'h1F7, 16'h1FF, 16'h0AD);
`else
        do_reset();
        run_seq("contend", 10, 16'h3FF, 16'h3FF, 16'h1EF);
        do_reset();
        run_seq("if_gap", 9, 16'h1F7, 16'h1FF, 16'h0FF);
`endif

        // Reset lands while a data read is in flight.
        do_reset();
        apply(mk(0, 32'h0, 1, 0, 32'h60, 32'h0, 32'h0, 0, 1, 0, 32'h60, 32'h0, 0, 0), "rst_grant");
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check_now(mk(1, 32'h44, 1, 0, 32'h60, 32'h0, 32'h77, 0, 0, 0, 32'h0, 32'h0, 0, 0), "rst_drop");
        apply(mk(1, 32'h44, 1, 1, 32'h60, 32'h9, 32'h78, 0, 0, 0, 32'h0, 32'h0, 0, 0), "rst_hold");
        @(negedge clk);
        reset = 1'b0;
        check_now(mk(1, 32'h44, 0, 0, 32'h0, 32'h0, 32'h79, 1, 0, 0, 32'h44, 32'h0, 0, 0), "rst_first");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h7A, 0, 0, 0, 32'h0, 32'h0, 1, 0), "rst_after");
        apply(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h7B, 0, 0, 0, 32'h0, 32'h0, 0, 0), "rst_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: XLEN, default 32, data width; AW, default 32, word-address width; MAX_WAIT, default 4, fetch starvation limit in cycles (range 1..15).
REQ-002 Ports, in order: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-003 if_req  in  1  fetch request; if_addr  in  AW  fetch word address; if_gnt  out  1  fetch accepted this cycle.
REQ-004 if_rvalid  out  1  fetch data valid; if_rdata  out  XLEN  fetch data.
REQ-005 d_req  in  1  data request; d_we  in  1  1=write; d_addr  in  AW  data word address; d_wdata  in  XLEN  write data; d_gnt  out  1  data accepted.
REQ-006 d_rvalid  out  1  load data valid; d_rdata  out  XLEN  load data.
REQ-007 mem_req  out  1  memory access strobe; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  XLEN; mem_rdata  in  XLEN  returned one cycle after the accepting mem_req.

Function
REQ-008 At most one grant per cycle; if_gnt and d_gnt SHALL be combinational from the current requests and state and SHALL never both be 1.
REQ-009 A requester holds req, addr, we and wdata stable until its gnt; the transfer completes in the cycle where req and gnt are both 1.
REQ-010 mem_req = if_gnt | d_gnt; mem_addr, mem_we and mem_wdata SHALL come from the granted requester; when idle, mem_we = 0 and mem_addr/mem_wdata = 0.
REQ-011 Fetch reads use mem_we = 0 regardless of d_we.
REQ-012 Read latency is exactly 1 cycle: a granted read at cycle N drives the owner's rvalid = 1 and rdata = mem_rdata at cycle N+1.
REQ-013 A granted write produces no rvalid.
REQ-014 Owner register: {rd_pending, owner_is_data}, loaded every cycle from the grant; rvalid of the non-owner SHALL be 0; if_rdata and d_rdata SHALL both mirror mem_rdata (only rvalid qualifies).
REQ-015 Back-to-back grants SHALL be allowed every cycle, including a grant at N+1 while returning data for N.
REQ-016 Only one requester active: grant it immediately (0-cycle arbitration latency).
REQ-017 Both active, default policy (macro undefined): data wins, except when wait_cnt = MAX_WAIT, then fetch wins.
REQ-018 wait_cnt (4 bits): increments when if_req=1 and if_gnt=0; clears when if_gnt=1 or if_req=0; saturates at MAX_WAIT.
REQ-019 Neither request active: no grant, state unchanged except rd_pending -> 0 and wait_cnt -> 0.

Reset
REQ-020 While reset = 1: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we = 0; mem_addr, mem_wdata = 0; rd_pending = 0, owner_is_data = 0, wait_cnt = 0, last_grant = fetch.
REQ-021 Reset asserted with a read in flight SHALL drop that read; no rvalid after reset release for a pre-reset grant.
REQ-022 First cycle after reset deassertion SHALL accept requests.

Configuration
REQ-023 Macro MEM_ARB_RR_EN: when defined, contention resolves round-robin: the requester not granted last (last_grant register, updated on every grant) wins; wait_cnt and MAX_WAIT are unused and wait_cnt is held 0.
REQ-024 MEM_ARB_RR_EN undefined: policy of REQ-017/REQ-018; last_grant still updated but unused.

Verification
REQ-025 Fetch only: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1 same cycle, mem_addr=0x10, if_rvalid=1 and if_rdata=0xDEADBEEF next cycle, d_rvalid=0.
REQ-026 Contention, default build, MAX_WAIT=4: if_req and d_req (reads) held 1 continuously -> d_gnt for 4 cycles, if_gnt on the 5th, pattern repeats; never both gnts.
REQ-027 Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678, d_gnt=1; no d_rvalid next cycle.
REQ-028 MEM_ARB_RR_EN build, both requesting reads continuously from reset -> grants alternate data, fetch, data, fetch (last_grant=fetch at reset); rvalid follows owner one cycle later.
REQ-029 Reset mid-read: d read granted at cycle N, reset asserted at N+1 before edge -> d_rvalid=0 at N+1 and after release; all outputs 0 during reset.
REQ-030 Idle gap: fetch granted at N, no requests at N+1 -> if_rvalid=1 at N+1, mem_req=0 at N+1, all rvalid=0 at N+2.
